piece_move_ctrl: RTL and testbench
==================================

PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

Interface
REQ-001 Parameter BOARD_W, default 10, board width in cells.
REQ-002 Parameter BOARD_H, default 20, board height in cells.
REQ-003 Parameter CELL_PIX, default 16, cell edge in pixels.
REQ-004 Parameter ORG_X, default 240, pixel x of board cell (0,0).
REQ-005 Parameter ORG_Y, default 80, pixel y of board cell (0,0).
REQ-006 Parameter DROP_FRAMES, default 30, frames per gravity step (>=1).
REQ-007 Parameter REPEAT_FRAMES, default 8, auto-repeat period in frames (>=1).
REQ-008 iVGA_CLK  in  1  single clock; all state on rising edge.
REQ-009 iRST_n  in  1  asynchronous, active-low reset.
REQ-010 iVS  in  1  active-low vertical sync, synchronous to iVGA_CLK.
REQ-011 move  in  4  button levels: [0] left, [1] right, [2] soft drop, [3] hard drop.
REQ-012 oCellX  out  4  piece column.
REQ-013 oCellY  out  5  piece row.
REQ-014 oPixX  out  10  ORG_X + oCellX*CELL_PIX, top-left pixel.
REQ-015 oPixY  out  9  ORG_Y + oCellY*CELL_PIX, top-left pixel.
REQ-016 oLanded  out  1  one-cycle pulse when the piece lands.

Function
REQ-017 Frame tick SHALL assert for exactly one cycle when iVS is sampled 0 and its previous registered sample was 1.
REQ-018 FSM states SHALL be WAIT, MOVE, FALL, LAND; outputs registered.
REQ-019 WAIT -> MOVE on the edge after a frame tick; otherwise stay in WAIT.
REQ-020 At the tick, a press SHALL be taken for each move bit that is 1 now and was 0 at the previous tick (edge per frame).
REQ-021 MOVE: left decrements oCellX unless 0; right increments unless BOARD_W-1; left and right together SHALL leave oCellX unchanged; next state FALL.
REQ-022 Gravity counter SHALL increment per frame tick; drop request when it reaches DROP_FRAMES-1, counter then clears.
REQ-023 Soft-drop press SHALL also raise a drop request and clear the gravity counter.
REQ-024 FALL: hard-drop press SHALL set oCellY to BOARD_H-1 and go to LAND (priority over everything else).
REQ-025 FALL: drop request with oCellY < BOARD_H-1 SHALL increment oCellY, go to WAIT; with oCellY = BOARD_H-1 go to LAND; no request, go to WAIT.
REQ-026 LAND: oLanded SHALL be 1 for exactly that cycle; on exit oCellX = BOARD_W/2, oCellY = 0, gravity counter 0; next state WAIT.
REQ-027 A frame tick arriving while not in WAIT SHALL be dropped (not queued).
REQ-028 oPixX/oPixY SHALL be combinational from oCellX/oCellY, full width, no truncation for default parameters.
REQ-029 Latency: tick at edge k -> oCellX valid at k+2, oCellY valid at k+3, oLanded at k+3 when landing.

Reset
REQ-030 While iRST_n = 0: state WAIT, oCellX = BOARD_W/2, oCellY = 0, oLanded = 0, counters 0, previous iVS sample 1, previous move sample 0.
REQ-031 Reset assertion mid-FSM SHALL abort immediately with no oLanded pulse; the first tick after release behaves as from power-up.

Configuration
REQ-032 Macro PIECE_AUTO_REPEAT_EN defined: a left/right/soft-drop bit held continuously SHALL generate an additional press every REPEAT_FRAMES ticks after its initial press; per-bit hold counter clears on release.
REQ-033 Macro absent: only edge presses per REQ-020; hold counters not synthesised.

Verification
REQ-034 Reset with defaults -> oCellX=5, oCellY=0, oPixX=320, oPixY=80, oLanded=0.
REQ-035 move=0001 held 20 frames, macro off -> oCellX 5->4 once; macro on -> 4 at frame 1, 3 at frame 9, 2 at frame 17.
REQ-036 Press left 6 times (separate frames) from reset -> oCellX reaches 0 and stays 0.
REQ-037 No input for 30 frames -> oCellY=1 three cycles after the 30th tick; after 600 frames total -> oLanded pulses once, position 5,0.
REQ-038 move=1000 at one tick -> oLanded=1 at k+3 for one cycle, then oCellX=5, oCellY=0; move=0011 at one tick -> oCellX unchanged.
REQ-039 iRST_n low during state FALL -> outputs at reset values same cycle, no oLanded pulse.

Source files
------------

// File: rtl/piece_move_ctrl_if.sv
// Signal bundle between the piece controller and its frame/button source.
// The master drives sync and buttons; the slave returns piece position.
interface piece_move_ctrl_if;
    logic       iVS;
    logic [3:0] move;
    logic [3:0] oCellX;
    logic [4:0] oCellY;
    logic [9:0] oPixX;
    logic [8:0] oPixY;
    logic       oLanded;

    modport master (
        output iVS, move,
        input  oCellX, oCellY, oPixX, oPixY, oLanded
    );

    modport slave (
        input  iVS, move,
        output oCellX, oCellY, oPixX, oPixY, oLanded
    );
endinterface

// File: rtl/piece_move_ctrl.sv
// Falling-piece position controller, stepped once per video frame.
// Optional macro PIECE_AUTO_REPEAT_EN adds held-button auto-repeat.
module piece_move_ctrl #(
    parameter int BOARD_W       = 10,
    parameter int BOARD_H       = 20,
    parameter int CELL_PIX      = 16,
    parameter int ORG_X         = 240,
    parameter int ORG_Y         = 80,
    parameter int DROP_FRAMES   = 30,
    parameter int REPEAT_FRAMES = 8
) (
    input  logic             iVGA_CLK,
    input  logic             iRST_n,
    piece_move_ctrl_if.slave bus
);

    typedef enum logic [1:0] {WAIT, MOVE, FALL, LAND} state_t;

    localparam int GW = $clog2(DROP_FRAMES + 1);
    localparam logic [3:0]    X_HOME = 4'(BOARD_W / 2);
    localparam logic [3:0]    X_MAX  = 4'(BOARD_W - 1);
    localparam logic [4:0]    Y_MAX  = 5'(BOARD_H - 1);
    localparam logic [GW-1:0] G_TOP  = GW'(DROP_FRAMES - 1);

    state_t        state_q, state_d;
    logic          vs_q, tick_q;
    logic [3:0]    mprev_q, mprev_d;
    logic [3:0]    press_q, press_d;
    logic          drop_q, drop_d;
    logic [GW-1:0] grav_q, grav_d;
    logic [3:0]    x_q, x_d;
    logic [4:0]    y_q, y_d;
    logic          land_q, land_d;

`ifdef PIECE_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] R_TOP = RW'(REPEAT_FRAMES - 1);

    logic [2:0][RW-1:0] hold_q, hold_d;

    // Per-button hold counters; only left, right and soft drop repeat
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) hold_q <= '0;
        else         hold_q <= hold_d;
    end
`endif

    // Frame tick: registered falling edge of vertical sync
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            vs_q   <= bus.iVS;
            tick_q <= vs_q & ~bus.iVS;
        end
    end

    // FSM and datapath state register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= WAIT;
            mprev_q <= '0;
            press_q <= '0;
            drop_q  <= 1'b0;
            grav_q  <= '0;
            x_q     <= X_HOME;
            y_q     <= '0;
            land_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mprev_q <= mprev_d;
            press_q <= press_d;
            drop_q  <= drop_d;
            grav_q  <= grav_d;
            x_q     <= x_d;
            y_q     <= y_d;
            land_q  <= land_d;
        end
    end

    // Next state: latch presses at tick, shift sideways, then apply gravity
    always_comb begin
        state_d = state_q;
        mprev_d = mprev_q;
        press_d = press_q;
        drop_d  = drop_q;
        grav_d  = grav_q;
        x_d     = x_q;
        y_d     = y_q;
        land_d  = 1'b0;
`ifdef PIECE_AUTO_REPEAT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            WAIT: begin
                if (tick_q) begin
                    state_d = MOVE;
                    mprev_d = bus.move;
                    press_d = bus.move & ~mprev_q;
`ifdef PIECE_AUTO_REPEAT_EN
                    for (int b = 0; b < 3; b++) begin
                        if (bus.move[b] && mprev_q[b]) begin
                            if (hold_q[b] == R_TOP) begin
                                hold_d[b]  = '0;
                                press_d[b] = 1'b1;
                            end else begin
                                hold_d[b] = hold_q[b] + RW'(1);
                            end
                        end else begin
                            hold_d[b] = '0;
                        end
                    end
`endif
                    if (grav_q == G_TOP) begin
                        grav_d = '0;
                        drop_d = 1'b1;
                    end else begin
                        grav_d = grav_q + GW'(1);
                        drop_d = 1'b0;
                    end
                    if (press_d[2]) begin
                        grav_d = '0;
                        drop_d = 1'b1;
                    end
                end
            end
            MOVE: begin
                state_d = FALL;
                if (press_q[0] && !press_q[1] && x_q != 4'd0)
                    x_d = x_q - 4'd1;
                else if (press_q[1] && !press_q[0] && x_q != X_MAX)
                    x_d = x_q + 4'd1;
            end
            FALL: begin
                if (press_q[3]) begin
                    y_d     = Y_MAX;
                    state_d = LAND;
                    land_d  = 1'b1;
                end else if (drop_q && y_q < Y_MAX) begin
                    y_d     = y_q + 5'd1;
                    state_d = WAIT;
                end else if (drop_q) begin
                    state_d = LAND;
                    land_d  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            LAND: begin
                x_d     = X_HOME;
                y_d     = '0;
                grav_d  = '0;
                state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    assign bus.oCellX  = x_q;
    assign bus.oCellY  = y_q;
    assign bus.oLanded = land_q;
    assign bus.oPixX   = 10'(ORG_X) + 10'(x_q) * 10'(CELL_PIX);
    assign bus.oPixY   = 9'(ORG_Y) + 9'(y_q) * 9'(CELL_PIX);

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed bench for piece_move_ctrl with hand-computed expectations.
// Expectations adapt to PIECE_AUTO_REPEAT_EN where behaviour differs.
module tb_piece_move_ctrl;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    int   land_cnt;

    logic [3:0] x2, x4;
    logic [4:0] y3, y4;
    logic       l3, l4;

    piece_move_ctrl_if bus ();

    piece_move_ctrl dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.oLanded === 1'b1) land_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.iVS  = 1'b1;
        bus.move = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        land_cnt = 0;
    endtask

    // One frame: tick edge E0, then sample at E2, E3, E4
    task automatic frame(input logic [3:0] m);
        @(negedge clk);
        bus.move = m;
        bus.iVS  = 1'b0;
        @(negedge clk);
        bus.iVS = 1'b1;
        @(negedge clk);
        @(negedge clk);
        x2 = bus.oCellX;
        @(negedge clk);
        y3 = bus.oCellY;
        l3 = bus.oLanded;
        @(negedge clk);
        l4 = bus.oLanded;
        x4 = bus.oCellX;
        y4 = bus.oCellY;
        repeat (2) @(negedge clk);
    endtask

    logic [3:0] exp_l1, exp_l9, exp_l17, exp_l20;

    initial begin
        n_run    = 0;
        n_fail   = 0;
        land_cnt = 0;
        rst_n    = 1'b0;
        bus.iVS  = 1'b1;
        bus.move = 4'b0000;
`ifdef PIECE_AUTO_REPEAT_EN
        exp_l1 = 4'd4; exp_l9 = 4'd3; exp_l17 = 4'd2; exp_l20 = 4'd2;
`else
        exp_l1 = 4'd4; exp_l9 = 4'd4; exp_l17 = 4'd4; exp_l20 = 4'd4;
`endif

        // Reset values
        @(negedge clk);
        chk("rst_x", 32'(bus.oCellX), 5);
        chk("rst_y", 32'(bus.oCellY), 0);
        chk("rst_px", 32'(bus.oPixX), 320);
        chk("rst_py", 32'(bus.oPixY), 80);
        chk("rst_land", 32'(bus.oLanded), 0);
        do_reset();

        // Left held for 20 frames
        for (int f = 1; f <= 20; f++) begin
            frame(4'b0001);
            if (f == 1)  chk("hold_f1", 32'(x2), 32'(exp_l1));
            if (f == 9)  chk("hold_f9", 32'(x2), 32'(exp_l9));
            if (f == 17) chk("hold_f17", 32'(x2), 32'(exp_l17));
        end
        chk("hold_f20", 32'(bus.oCellX), 32'(exp_l20));
        chk("hold_y", 32'(bus.oCellY), 0);

        // Six separate left presses reach and stick at column 0
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            frame(4'b0001);
            frame(4'b0000);
            if (i == 5) chk("left5", 32'(bus.oCellX), 0);
        end
        chk("left6", 32'(bus.oCellX), 0);
        chk("left_px", 32'(bus.oPixX), 240);

        // Six right presses stick at column 9
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            frame(4'b0010);
            frame(4'b0000);
        end
        chk("right6", 32'(bus.oCellX), 9);
        chk("right_px", 32'(bus.oPixX), 384);

        // Left and right together leave the column alone
        do_reset();
        frame(4'b0011);
        chk("lr_x", 32'(x2), 5);

        // Gravity: first step exactly at the 30th tick, k+3 latency
        do_reset();
        for (int f = 1; f <= 29; f++) frame(4'b0000);
        chk("grav29_y", 32'(bus.oCellY), 0);
        frame(4'b0000);
        chk("grav30_y", 32'(y3), 1);
        for (int f = 31; f <= 599; f++) frame(4'b0000);
        chk("grav599_y", 32'(bus.oCellY), 19);
        chk("grav599_land", 32'(land_cnt), 0);
        frame(4'b0000);
        chk("grav600_l3", 32'(l3), 1);
        chk("grav600_l4", 32'(l4), 0);
        chk("grav600_cnt", 32'(land_cnt), 1);
        chk("grav600_x", 32'(bus.oCellX), 5);
        chk("grav600_y", 32'(bus.oCellY), 0);

        // Hard drop after a sideways move
        do_reset();
        frame(4'b0001);
        frame(4'b1000);
        chk("hd_y3", 32'(y3), 19);
        chk("hd_l3", 32'(l3), 1);
        chk("hd_l4", 32'(l4), 0);
        chk("hd_x4", 32'(x4), 5);
        chk("hd_y4", 32'(y4), 0);
        chk("hd_cnt", 32'(land_cnt), 1);

        // Soft drop steps down once immediately
        do_reset();
        frame(4'b0100);
        chk("sd_y3", 32'(y3), 1);

        // Reset asserted while in FALL aborts without a landing pulse
        do_reset();
        frame(4'b0001);
        frame(4'b0000);
        @(negedge clk);
        bus.move = 4'b1001;
        bus.iVS  = 1'b0;
        @(negedge clk);
        bus.iVS = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fall_x_pre", 32'(bus.oCellX), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("frst_x", 32'(bus.oCellX), 5);
        chk("frst_y", 32'(bus.oCellY), 0);
        chk("frst_land", 32'(bus.oLanded), 0);
        repeat (3) @(negedge clk);
        bus.move = 4'b0000;
        rst_n    = 1'b1;
        repeat (3) @(negedge clk);
        chk("frst_cnt", 32'(land_cnt), 0);
        frame(4'b0001);
        chk("frst_after", 32'(x2), 4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
